// File: rtl/dmem_arbiter.sv
// Two-port (A = CPU MEM stage, B = loader/debug) arbiter and sequencer for a single-port data memory.
// One access per IDLE->ACCESS->RESP pass, ack two edges after req is seen. Requesters hold req until ack.
module dmem_arbiter #(
    parameter int unsigned DEPTH      = 256,
    parameter bit          FIXED_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    output logic        a_err,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        b_err,
    output logic [5:0]  mem_opcode,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_rt,
    input  logic [31:0] mem_out,
    output logic        busy,
    output logic        gnt_b
);

    localparam logic [5:0] OP_STORE = 6'b101011;
    localparam logic [5:0] OP_LOAD  = 6'b100011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_we, w_we_nxt;
    logic        r_err, w_err_nxt;
    logic        r_gnt_b, w_gnt_b_nxt;
    logic        r_last_gnt, w_last_gnt_nxt;
    logic [5:0]  r_mem_opcode, w_mem_opcode_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_mem_rt, w_mem_rt_nxt;
    logic        r_a_ack, w_a_ack_nxt;
    logic [31:0] r_a_rdata, w_a_rdata_nxt;
    logic        r_a_err, w_a_err_nxt;
    logic        r_b_ack, w_b_ack_nxt;
    logic [31:0] r_b_rdata, w_b_rdata_nxt;
    logic        r_b_err, w_b_err_nxt;

    logic        w_pick_b;
    logic        w_sel_we;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic        w_sel_err;
    logic [31:0] w_rdata;

    // On a tie, round-robin hands the grant to whichever port did not win last time.
    assign w_pick_b    = (a_req && b_req) ? (FIXED_PRIO ? 1'b0 : ~r_last_gnt) : b_req;
    assign w_sel_we    = w_pick_b ? b_we    : a_we;
    assign w_sel_addr  = w_pick_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_pick_b ? b_wdata : a_wdata;
    assign w_sel_err   = (w_sel_addr >= DEPTH);
    assign w_rdata     = (!r_we && !r_err) ? mem_out : 32'h0;

    always_comb begin
        w_state_nxt      = r_state;
        w_we_nxt         = r_we;
        w_err_nxt        = r_err;
        w_gnt_b_nxt      = r_gnt_b;
        w_last_gnt_nxt   = r_last_gnt;
        w_mem_opcode_nxt = 6'h0;
        w_mem_addr_nxt   = r_mem_addr;
        w_mem_rt_nxt     = r_mem_rt;
        w_a_ack_nxt      = 1'b0;
        w_a_rdata_nxt    = 32'h0;
        w_a_err_nxt      = 1'b0;
        w_b_ack_nxt      = 1'b0;
        w_b_rdata_nxt    = 32'h0;
        w_b_err_nxt      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (a_req || b_req) begin
                    w_gnt_b_nxt      = w_pick_b;
                    w_last_gnt_nxt   = w_pick_b;
                    w_we_nxt         = w_sel_we;
                    w_err_nxt        = w_sel_err;
                    w_mem_addr_nxt   = w_sel_addr;
                    w_mem_rt_nxt     = w_sel_wdata;
                    // Out-of-range accesses never reach the memory.
                    w_mem_opcode_nxt = w_sel_err ? 6'h0 : (w_sel_we ? OP_STORE : OP_LOAD);
                    w_state_nxt      = S_ACCESS;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
                if (r_gnt_b) begin
                    w_b_ack_nxt   = 1'b1;
                    w_b_rdata_nxt = w_rdata;
                    w_b_err_nxt   = r_err;
                end else begin
                    w_a_ack_nxt   = 1'b1;
                    w_a_rdata_nxt = w_rdata;
                    w_a_err_nxt   = r_err;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_err        <= 1'b0;
            r_gnt_b      <= 1'b0;
            r_last_gnt   <= 1'b1;
            r_mem_opcode <= 6'h0;
            r_mem_addr   <= 32'h0;
            r_mem_rt     <= 32'h0;
            r_a_ack      <= 1'b0;
            r_a_rdata    <= 32'h0;
            r_a_err      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_b_rdata    <= 32'h0;
            r_b_err      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_we         <= w_we_nxt;
            r_err        <= w_err_nxt;
            r_gnt_b      <= w_gnt_b_nxt;
            r_last_gnt   <= w_last_gnt_nxt;
            r_mem_opcode <= w_mem_opcode_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_rt     <= w_mem_rt_nxt;
            r_a_ack      <= w_a_ack_nxt;
            r_a_rdata    <= w_a_rdata_nxt;
            r_a_err      <= w_a_err_nxt;
            r_b_ack      <= w_b_ack_nxt;
            r_b_rdata    <= w_b_rdata_nxt;
            r_b_err      <= w_b_err_nxt;
        end
    end

    assign a_ack      = r_a_ack;
    assign a_rdata    = r_a_rdata;
    assign a_err      = r_a_err;
    assign b_ack      = r_b_ack;
    assign b_rdata    = r_b_rdata;
    assign b_err      = r_b_err;
    assign mem_opcode = r_mem_opcode;
    assign mem_addr   = r_mem_addr;
    assign mem_rt     = r_mem_rt;
    assign busy       = (r_state != S_IDLE);
    assign gnt_b      = r_gnt_b;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin and fixed-priority instances, each backed by a negedge-write memory model.
module tb_dmem_arbiter;

    localparam logic [5:0] OP_ST = 6'b101011;
    localparam logic [5:0] OP_LD = 6'b100011;

    typedef struct {
        bit          port_b;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err, busy, gnt_b;
    logic [31:0] a_rdata, b_rdata, mem_addr, mem_rt, mem_out;
    logic [5:0]  mem_opcode;

    logic        fp_a_req, fp_a_we, fp_b_req, fp_b_we;
    logic [31:0] fp_a_addr, fp_a_wdata, fp_b_addr, fp_b_wdata;
    logic        fp_a_ack, fp_a_err, fp_b_ack, fp_b_err, fp_busy, fp_gnt_b;
    logic [31:0] fp_a_rdata, fp_b_rdata, fp_mem_addr, fp_mem_rt, fp_mem_out;
    logic [5:0]  fp_mem_opcode;

    logic [31:0] mem_rr [0:255] = '{default: 32'h0};
    logic [31:0] mem_fp [0:255] = '{default: 32'h0};

    always @(negedge clk) begin
        if (mem_opcode == OP_ST && mem_addr < 32'd256) mem_rr[mem_addr[7:0]] <= mem_rt;
        if (fp_mem_opcode == OP_ST && fp_mem_addr < 32'd256) mem_fp[fp_mem_addr[7:0]] <= fp_mem_rt;
    end
    assign mem_out    = (mem_addr < 32'd256) ? mem_rr[mem_addr[7:0]] : 32'h0;
    assign fp_mem_out = (fp_mem_addr < 32'd256) ? mem_fp[fp_mem_addr[7:0]] : 32'h0;

    dmem_arbiter #(.DEPTH(256), .FIXED_PRIO(1'b0)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
        .mem_opcode(mem_opcode), .mem_addr(mem_addr), .mem_rt(mem_rt), .mem_out(mem_out),
        .busy(busy), .gnt_b(gnt_b)
    );

    dmem_arbiter #(.DEPTH(256), .FIXED_PRIO(1'b1)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .a_req(fp_a_req), .a_we(fp_a_we), .a_addr(fp_a_addr), .a_wdata(fp_a_wdata),
        .a_ack(fp_a_ack), .a_rdata(fp_a_rdata), .a_err(fp_a_err),
        .b_req(fp_b_req), .b_we(fp_b_we), .b_addr(fp_b_addr), .b_wdata(fp_b_wdata),
        .b_ack(fp_b_ack), .b_rdata(fp_b_rdata), .b_err(fp_b_err),
        .mem_opcode(fp_mem_opcode), .mem_addr(fp_mem_addr), .mem_rt(fp_mem_rt), .mem_out(fp_mem_out),
        .busy(fp_busy), .gnt_b(fp_gnt_b)
    );

    int   checks = 0;
    int   failures = 0;
    exp_t sb_q[$];
    exp_t e;

    bit          got, pb, er, gb;
    logic [31:0] rd;
    logic [5:0]  op;
    int          lat;

    task automatic drive_a(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
        a_req = req; a_we = we; a_addr = addr; a_wdata = data;
    endtask

    task automatic drive_b(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] data);
        b_req = req; b_we = we; b_addr = addr; b_wdata = data;
    endtask

    // Waits (bounded) for the next ack; latency counts negedges from the drive point. No comparisons here.
    task automatic collect(input bit fp, output bit o_got, output bit o_pb, output logic [31:0] o_rd,
                           output bit o_er, output int o_lat, output logic [5:0] o_op, output bit o_gb);
        o_got = 0; o_pb = 0; o_rd = 32'h0; o_er = 0; o_lat = 0; o_op = 6'h0; o_gb = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if ((fp ? fp_mem_opcode : mem_opcode) != 6'h0) o_op = fp ? fp_mem_opcode : mem_opcode;
            if (fp ? (fp_a_ack || fp_b_ack) : (a_ack || b_ack)) begin
                o_got = 1;
                o_pb  = fp ? fp_b_ack : b_ack;
                o_rd  = fp ? (fp_b_ack ? fp_b_rdata : fp_a_rdata) : (b_ack ? b_rdata : a_rdata);
                o_er  = fp ? (fp_b_ack ? fp_b_err : fp_a_err) : (b_ack ? b_err : a_err);
                o_gb  = fp ? fp_gnt_b : gnt_b;
                o_lat = i;
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_a(1, 1, 32'd5, 32'h1111_2222);
        repeat (3) @(negedge clk);
        checks++;
        if ({a_ack, a_rdata, a_err, b_ack, b_rdata, b_err, mem_addr, mem_rt, gnt_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: acks=%b%b rdata=%h/%h errs=%b%b addr=%h rt=%h gnt_b=%b, required all 0",
                     a_ack, b_ack, a_rdata, b_rdata, a_err, b_err, mem_addr, mem_rt, gnt_b);
        end
        checks++;
        if ({busy, mem_opcode} !== 7'h0) begin
            failures++;
            $display("FAIL reset_busy_opcode: busy=%b opcode=%b, required 0/000000", busy, mem_opcode);
        end
        @(posedge clk); #1;
        drive_a(0, 0, 32'h0, 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic test_store_load();
        drive_a(1, 1, 32'd5, 32'hDEAD_BEEF);
        sb_q.push_back('{1'b0, 32'h0, 1'b0});
        collect(0, got, pb, rd, er, lat, op, gb);
        drive_a(0, 0, 32'h0, 32'h0);
        checks++;
        if (!got || lat != 3) begin
            failures++; $display("FAIL store_latency: got=%0d lat=%0d, required ack at 3", got, lat);
        end
        if (sb_q.size() != 0) e = sb_q.pop_front();
        checks++;
        if ({pb, rd, er, op, gb} !== {e.port_b, e.rdata, e.err, OP_ST, 1'b0}) begin
            failures++;
            $display("FAIL store_resp: port_b=%b rdata=%h err=%b op=%b gnt_b=%b, required %b %h %b %b 0",
                     pb, rd, er, op, gb, e.port_b, e.rdata, e.err, OP_ST);
        end
        drive_a(1, 0, 32'd5, 32'h0);
        sb_q.push_back('{1'b0, 32'hDEAD_BEEF, 1'b0});
        collect(0, got, pb, rd, er, lat, op, gb);
        drive_a(0, 0, 32'h0, 32'h0);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        checks++;
        if (!got || {pb, rd, er, op} !== {e.port_b, e.rdata, e.err, OP_LD}) begin
            failures++;
            $display("FAIL load_resp: got=%0d port_b=%b rdata=%h err=%b op=%b, required %b %h %b %b",
                     got, pb, rd, er, op, e.port_b, e.rdata, e.err, OP_LD);
        end
    endtask

    task automatic test_rr_tie();
        do_reset();
        drive_a(1, 0, 32'd5, 32'h0);
        drive_b(1, 0, 32'd9, 32'h0);
        for (int k = 0; k < 4; k++) sb_q.push_back('{k[0], (k[0] ? 32'h0 : 32'hDEAD_BEEF), 1'b0});
        for (int k = 0; k < 4; k++) begin
            collect(0, got, pb, rd, er, lat, op, gb);
            if (sb_q.size() != 0) e = sb_q.pop_front();
            checks++;
            if (!got || lat != 3 || {pb, rd, er, gb} !== {e.port_b, e.rdata, e.err, e.port_b}) begin
                failures++;
                $display("FAIL rr_tie_%0d: got=%0d lat=%0d port_b=%b rdata=%h err=%b gnt_b=%b, required lat 3 %b %h %b %b",
                         k, got, lat, pb, rd, er, gb, e.port_b, e.rdata, e.err, e.port_b);
            end
        end
        drive_a(0, 0, 32'h0, 32'h0);
        drive_b(0, 0, 32'h0, 32'h0);
    endtask

    task automatic test_fixed_prio();
        fp_a_req = 1; fp_a_we = 1; fp_a_addr = 32'd3; fp_a_wdata = 32'h0000_1234;
        fp_b_req = 1; fp_b_we = 0; fp_b_addr = 32'd4; fp_b_wdata = 32'h0;
        for (int k = 0; k < 4; k++) sb_q.push_back('{1'b0, 32'h0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            collect(1, got, pb, rd, er, lat, op, gb);
            if (sb_q.size() != 0) e = sb_q.pop_front();
            checks++;
            if (!got || {pb, rd, er, gb, op} !== {e.port_b, e.rdata, e.err, 1'b0, OP_ST}) begin
                failures++;
                $display("FAIL fixed_prio_%0d: got=%0d port_b=%b rdata=%h err=%b gnt_b=%b op=%b, required port A store",
                         k, got, pb, rd, er, gb, op);
            end
        end
        fp_a_req = 0; fp_b_req = 0;
        @(posedge clk); #1;
        checks++;
        if (fp_busy !== 1'b0 || mem_fp[3] !== 32'h0000_1234) begin
            failures++;
            $display("FAIL fixed_prio_idle: busy=%b mem[3]=%h, required 0 / 00001234", fp_busy, mem_fp[3]);
        end
    endtask

    task automatic test_range();
        logic [31:0] addrs [4];
        bit          wes   [4];
        addrs = '{32'd256, 32'd300, 32'h1000_0005, 32'd255};
        wes   = '{1'b0, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 4; k++) begin
            drive_b(1, wes[k], addrs[k], 32'hCAFE_F00D);
            sb_q.push_back('{1'b1, 32'h0, (addrs[k] >= 32'd256)});
            collect(0, got, pb, rd, er, lat, op, gb);
            drive_b(0, 0, 32'h0, 32'h0);
            if (sb_q.size() != 0) e = sb_q.pop_front();
            checks++;
            if (!got || {pb, rd, er, gb} !== {e.port_b, e.rdata, e.err, 1'b1}) begin
                failures++;
                $display("FAIL range_%0d: got=%0d port_b=%b rdata=%h err=%b gnt_b=%b, required %b %h %b 1",
                         k, got, pb, rd, er, gb, e.port_b, e.rdata, e.err);
            end
            checks++;
            if (op !== (e.err ? 6'h0 : OP_LD)) begin
                failures++; $display("FAIL range_opcode_%0d: op=%b, required %b", k, op, e.err ? 6'h0 : OP_LD);
            end
        end
        checks++;
        if (mem_rr[44] !== 32'h0 || mem_rr[5] !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL range_store_mem: mem[44]=%h mem[5]=%h, required 00000000 / deadbeef", mem_rr[44], mem_rr[5]);
        end
    endtask

    task automatic test_drop();
        drive_a(1, 1, 32'd12, 32'd55);
        sb_q.push_back('{1'b0, 32'h0, 1'b0});
        @(posedge clk); #1;
        drive_a(0, 0, 32'h0, 32'h0);
        collect(0, got, pb, rd, er, lat, op, gb);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        checks++;
        if (!got || lat != 2 || {pb, rd, er} !== {e.port_b, e.rdata, e.err}) begin
            failures++;
            $display("FAIL drop_ack: got=%0d lat=%0d port_b=%b rdata=%h err=%b, required ack after 2 more",
                     got, lat, pb, rd, er);
        end
        drive_a(1, 0, 32'd12, 32'h0);
        sb_q.push_back('{1'b0, 32'd55, 1'b0});
        collect(0, got, pb, rd, er, lat, op, gb);
        drive_a(0, 0, 32'h0, 32'h0);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        checks++;
        if (!got || {pb, rd, er} !== {e.port_b, e.rdata, e.err}) begin
            failures++;
            $display("FAIL drop_readback: got=%0d port_b=%b rdata=%h err=%b, required %b %h %b",
                     got, pb, rd, er, e.port_b, e.rdata, e.err);
        end
    endtask

    task automatic test_abort();
        bit seen = 0;
        drive_a(1, 1, 32'd7, 32'd1);
        @(posedge clk);
        #2;
        checks++;
        if (mem_opcode !== OP_ST) begin
            failures++; $display("FAIL abort_in_access: op=%b, required %b", mem_opcode, OP_ST);
        end
        rst_n = 1'b0;
        drive_a(0, 0, 32'h0, 32'h0);
        #1;
        checks++;
        if (mem_opcode !== 6'h0 || busy !== 1'b0) begin
            failures++; $display("FAIL abort_clear: op=%b busy=%b, required 000000 / 0", mem_opcode, busy);
        end
        repeat (4) begin
            @(negedge clk);
            if (a_ack || b_ack) seen = 1;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (a_ack || b_ack) seen = 1;
        end
        checks++;
        if (seen !== 1'b0 || mem_rr[7] !== 32'h0) begin
            failures++; $display("FAIL abort_no_ack: ack_seen=%b mem[7]=%h, required 0 / 00000000", seen, mem_rr[7]);
        end
        @(posedge clk); #1;
        drive_a(1, 0, 32'd7, 32'h0);
        sb_q.push_back('{1'b0, 32'h0, 1'b0});
        collect(0, got, pb, rd, er, lat, op, gb);
        drive_a(0, 0, 32'h0, 32'h0);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        checks++;
        if (!got || {pb, rd, er} !== {e.port_b, e.rdata, e.err}) begin
            failures++;
            $display("FAIL abort_readback: got=%0d port_b=%b rdata=%h err=%b, required %b %h %b",
                     got, pb, rd, er, e.port_b, e.rdata, e.err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_a(0, 0, 32'h0, 32'h0);
        drive_b(0, 0, 32'h0, 32'h0);
        fp_a_req = 0; fp_a_we = 0; fp_a_addr = 32'h0; fp_a_wdata = 32'h0;
        fp_b_req = 0; fp_b_we = 0; fp_b_addr = 32'h0; fp_b_wdata = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_store_load();
        test_rr_tie();
        test_fixed_prio();
        test_range();
        test_drop();
        test_abort();
        checks++;
        if (sb_q.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain: left=%0d, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
